// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search engine.
// Message-checker state encoding and printable-byte bounds.
package rc4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    FINISH
  } msg_chk_state_t;

  localparam logic [7:0] CHAR_LO = 8'h61;
  localparam logic [7:0] CHAR_HI = 8'h7A;
  localparam logic [7:0] CHAR_SP = 8'h20;

  localparam int MESSAGE_LENGTH = 32;

endpackage

// File: rtl/ascii_class.sv
// Printable-byte classifier for decrypted message bytes.
// Accepts 'a'..'z', plus space when allow_space is set.
module ascii_class
  import rc4_pkg::*;
(
  input  logic [7:0] data,
  input  logic       allow_space,
  output logic       valid
);

  logic is_lower;
  logic is_space;

  assign is_lower = (data >= CHAR_LO) && (data <= CHAR_HI);
  assign is_space = allow_space && (data == CHAR_SP);
  assign valid    = is_lower || is_space;

endmodule

// File: rtl/msg_checker.sv
// Scans the decrypted-message RAM after each start pulse and
// reports whether every byte is printable (first bad byte kept).
module msg_checker
  import rc4_pkg::*;
#(
  parameter int MSG_LEN      = MESSAGE_LENGTH,
  parameter int ADDR_W       = 5,
  parameter int READ_LATENCY = 2,
  parameter int ALLOW_SPACE  = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] bad_index,
  output logic [7:0]        bad_byte
);

  localparam int CNT_W = 3;
  localparam logic [ADDR_W:0] LAST =
    (ADDR_W+1)'(MSG_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(READ_LATENCY - 1);

  msg_chk_state_t    state, state_n;
  logic [ADDR_W:0]   k, k_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] addr_n, idx_n;
  logic [7:0]        byte_n;
  logic              busy_n, done_n, pass_n;
  logic              valid;

  ascii_class u_class (
    .data        (rd_data),
    .allow_space (ALLOW_SPACE != 0),
    .valid       (valid)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state     <= IDLE;
      k         <= '0;
      cnt       <= '0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      bad_index <= '0;
      bad_byte  <= '0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      cnt       <= cnt_n;
      rd_addr   <= addr_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      bad_index <= idx_n;
      bad_byte  <= byte_n;
    end
  end

  // done is registered, so it is raised on the edge entering FINISH
  always_comb begin
    state_n = state;
    k_n     = k;
    cnt_n   = cnt;
    addr_n  = rd_addr;
    busy_n  = busy;
    done_n  = 1'b0;
    pass_n  = pass;
    idx_n   = bad_index;
    byte_n  = bad_byte;
    unique case (state)
      IDLE: begin
        if (start) begin
          busy_n  = 1'b1;
          k_n     = '0;
          pass_n  = 1'b0;
          idx_n   = '0;
          byte_n  = '0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        addr_n  = k[ADDR_W-1:0];
        cnt_n   = CNT_LOAD;
        state_n = (READ_LATENCY == 1) ? CHECK : WAIT;
      end
      WAIT: begin
        cnt_n = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_n = CHECK;
      end
      CHECK: begin
        if (!valid) begin
          idx_n   = k[ADDR_W-1:0];
          byte_n  = rd_data;
          pass_n  = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = FINISH;
        end else if (k == LAST) begin
          pass_n  = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = FINISH;
        end else begin
          k_n     = k + 1'b1;
          state_n = ISSUE;
        end
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_msg_checker.sv
// Self-checking bench: four msg_checker builds (latency 2/1/4,
// space on/off) share one message RAM image and one start.
module tb_msg_checker;

  localparam int N = 4;
  localparam int LAT [N] = '{2, 1, 4, 2};
  localparam int SPC [N] = '{1, 1, 1, 0};
  localparam int SCAN_EDGES = 200;

  logic       CLOCK_50;
  logic       reset_n;
  logic       start;
  logic [4:0] rd_addr   [N];
  logic [7:0] rd_data   [N];
  logic       busy      [N];
  logic       done      [N];
  logic       pass      [N];
  logic [4:0] bad_index [N];
  logic [7:0] bad_byte  [N];
  logic [7:0] mem       [32];

  int n_cmp = 0;
  int n_bad = 0;

  int r_cnt  [N];
  int r_cyc  [N];
  int r_busy [N];
  int r_max  [N];
  int r_pass [N];
  int r_idx  [N];
  int r_byte [N];
  int r_hold [N];

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // RAM models: rd_data reflects the address LAT edges later
  logic [4:0] p0, p3, q1, q2, q3;
  always @(posedge CLOCK_50) begin
    p0 <= rd_addr[0];
    p3 <= rd_addr[3];
    q1 <= rd_addr[2];
    q2 <= q1;
    q3 <= q2;
  end
  assign rd_data[0] = mem[p0];
  assign rd_data[1] = mem[rd_addr[1]];
  assign rd_data[2] = mem[q3];
  assign rd_data[3] = mem[p3];

  for (genvar g = 0; g < N; g++) begin : g_dut
    msg_checker #(
      .MSG_LEN      (32),
      .ADDR_W       (5),
      .READ_LATENCY (LAT[g]),
      .ALLOW_SPACE  (SPC[g])
    ) dut (
      .CLOCK_50  (CLOCK_50),
      .reset_n   (reset_n),
      .start     (start),
      .rd_addr   (rd_addr[g]),
      .rd_data   (rd_data[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .pass      (pass[g]),
      .bad_index (bad_index[g]),
      .bad_byte  (bad_byte[g])
    );
  end

  typedef struct {
    string    name;
    logic [7:0] fill;
    int       bad_pos;
    logic [7:0] bad_val;
    bit       space_odd;
    bit       e_pass;
    int       e_idx;
    int       e_byte;
    int       e_cyc;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit is_ok(input logic [7:0] b, input int sp);
    return (b >= 8'h61 && b <= 8'h7A) || (sp != 0 && b == 8'h20);
  endfunction

  // Reference: first byte failing the printable rule ends the scan
  task automatic ref_scan(input int d, output bit p, output int idx,
                          output int b, output int cyc);
    p   = 1'b1;
    idx = 0;
    b   = 0;
    cyc = 1 + 32 * (LAT[d] + 1) + 1;
    for (int i = 0; i < 32; i++) begin
      if (!is_ok(mem[i], SPC[d])) begin
        p   = 1'b0;
        idx = i;
        b   = mem[i];
        cyc = 1 + (i + 1) * (LAT[d] + 1) + 1;
        break;
      end
    end
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 32; i++) mem[i] = v;
  endtask

  task automatic check_zero(input int d, input string tag);
    chk($sformatf("%s d%0d busy", tag, d), busy[d], 0);
    chk($sformatf("%s d%0d done", tag, d), done[d], 0);
    chk($sformatf("%s d%0d pass", tag, d), pass[d], 0);
    chk($sformatf("%s d%0d idx", tag, d), bad_index[d], 0);
    chk($sformatf("%s d%0d byte", tag, d), bad_byte[d], 0);
    chk($sformatf("%s d%0d addr", tag, d), rd_addr[d], 0);
  endtask

  task automatic sample(input int e);
    for (int d = 0; d < N; d++) begin
      if (busy[d]) r_busy[d]++;
      if (e >= 2 && r_cnt[d] == 0 && int'(rd_addr[d]) > r_max[d])
        r_max[d] = rd_addr[d];
      if (done[d]) begin
        r_cnt[d]++;
        r_cyc[d]  = e + 1;
        r_pass[d] = pass[d];
        r_idx[d]  = bad_index[d];
        r_byte[d] = bad_byte[d];
      end
    end
  endtask

  task automatic run_scan(input bit repulse);
    for (int d = 0; d < N; d++) begin
      r_cnt[d] = 0; r_cyc[d] = 0; r_busy[d] = 0; r_max[d] = 0;
      r_pass[d] = -1; r_idx[d] = -1; r_byte[d] = -1;
    end
    start = 1'b1;
    for (int e = 1; e <= SCAN_EDGES; e++) begin
      @(posedge CLOCK_50);
      #1;
      if (e == 1) start = 1'b0;
      sample(e);
      if (repulse && e == 9) start = 1'b1;
      if (repulse && e == 10) start = 1'b0;
    end
    for (int d = 0; d < N; d++) r_hold[d] = pass[d];
  endtask

  task automatic check_dut(input int d, input string tag, input bit ep,
                           input int ei, input int eb, input int ec);
    chk($sformatf("%s d%0d done_count", tag, d), r_cnt[d], 1);
    chk($sformatf("%s d%0d pass", tag, d), r_pass[d], ep);
    chk($sformatf("%s d%0d bad_index", tag, d), r_idx[d], ei);
    chk($sformatf("%s d%0d bad_byte", tag, d), r_byte[d], eb);
    chk($sformatf("%s d%0d cycles", tag, d), r_cyc[d], ec);
    chk($sformatf("%s d%0d busy_cycles", tag, d), r_busy[d], ec - 2);
    chk($sformatf("%s d%0d max_addr", tag, d), r_max[d], ep ? 31 : ei);
    chk($sformatf("%s d%0d pass_held", tag, d), r_hold[d], ep);
  endtask

  task automatic check_all_ref(input string tag);
    bit p; int i, b, c;
    for (int d = 0; d < N; d++) begin
      ref_scan(d, p, i, b, c);
      check_dut(d, tag, p, i, b, c);
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(posedge CLOCK_50);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int e, d1, d2, seen;
    bit prev;

    vecs[0] = '{"all_a", 8'h61, -1, 8'h00, 0, 1, 0, 0, 98};
    vecs[1] = '{"bad7", 8'h7A, 7, 8'h41, 0, 0, 7, 8'h41, 26};
    vecs[2] = '{"bad31", 8'h6D, 31, 8'h7B, 0, 0, 31, 8'h7B, 98};
    vecs[3] = '{"bad0", 8'h61, 0, 8'h60, 0, 0, 0, 8'h60, 5};
    vecs[4] = '{"spaces", 8'h71, -1, 8'h00, 1, 1, 0, 0, 98};

    reset_n = 1'b0;
    start   = 1'b0;
    fill_mem(8'h61);
    repeat (3) @(posedge CLOCK_50);
    #1;
    for (int d = 0; d < N; d++) check_zero(d, "reset");
    reset_n = 1'b1;
    @(posedge CLOCK_50);
    #1;

    foreach (vecs[v]) begin
      fill_mem(vecs[v].fill);
      if (vecs[v].space_odd)
        for (int i = 1; i < 32; i += 2) mem[i] = 8'h20;
      if (vecs[v].bad_pos >= 0) mem[vecs[v].bad_pos] = vecs[v].bad_val;
      run_scan(1'b0);
      check_dut(0, vecs[v].name, vecs[v].e_pass, vecs[v].e_idx,
                vecs[v].e_byte, vecs[v].e_cyc);
      for (int d = 1; d < N; d++) begin
        bit p; int i, b, c;
        ref_scan(d, p, i, b, c);
        check_dut(d, vecs[v].name, p, i, b, c);
      end
    end
    chk("spaces d3 first_space", r_idx[3], 1);

    // Reset mid-scan at byte 15
    fill_mem(8'h61);
    start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    e = 0;
    while (rd_addr[0] != 5'd15 && e < 200) begin
      @(posedge CLOCK_50);
      #1;
      e++;
    end
    chk("midreset reach15", (e < 200) ? 1 : 0, 1);
    pulse_reset();
    check_zero(0, "midreset");
    seen = 0;
    repeat (SCAN_EDGES) begin
      @(posedge CLOCK_50);
      #1;
      for (int d = 0; d < N; d++) if (done[d]) seen++;
    end
    chk("midreset no_done", seen, 0);
    run_scan(1'b0);
    check_all_ref("after_reset");

    // start re-pulsed while busy is ignored
    run_scan(1'b1);
    check_all_ref("repulse");

    // start held high: re-accepted on the IDLE cycle after done
    start = 1'b1;
    d1 = -1; d2 = -1; prev = 1'b0; seen = 0;
    for (int i = 1; i <= 300 && d2 < 0; i++) begin
      @(posedge CLOCK_50);
      #1;
      if (done[0] && prev) seen++;
      if (done[0] && !prev) begin
        if (d1 < 0) d1 = i;
        else d2 = i;
      end
      prev = done[0];
    end
    start = 1'b0;
    chk("hold first_done_edge", d1, 97);
    chk("hold done_spacing", d2 - d1, 98);
    chk("hold no_back_to_back", seen, 0);
    pulse_reset();

    for (int t = 0; t < 20; t++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 32; i++) begin
        mem[i] = 8'h61 + 8'($urandom_range(0, 25));
        if ($urandom_range(0, 7) == 0) mem[i] = 8'h20;
      end
      if (mode == 1) mem[$urandom_range(0, 31)] = 8'($urandom_range(0, 255));
      if (mode == 2)
        repeat (3) mem[$urandom_range(0, 31)] = 8'($urandom_range(0, 255));
      run_scan(1'b0);
      check_all_ref($sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
